// File: rtl/pio_bidir_irq.sv
// ---------------------------------------------------------------------------
// pio_bidir_irq
//   Bidirectional parallel I/O peripheral with an Avalon-MM slave port.
//   It has a WIDTH-bit pin bank, a per-bit direction register and set/clear
//   strobes for atomic output updates. Inputs are synchronised, then
//   edge-captured into a write-1-to-clear register that drives a maskable
//   level interrupt.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   address     register word address (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP,
//               4 OUTSET, 5 OUTCLR, 6-7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data; only the low WIDTH bits are used
//   readdata    registered read data, one cycle latency, zero-extended
//   bidir_port  pins; bit i is driven with data_out[i] when dir[i]=1, else Z
//   irq         level interrupt, |(edge_cap & irq_mask)
// ---------------------------------------------------------------------------
module pio_bidir_irq #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 EDGE_TYPE   = 0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  inout  wire  [WIDTH-1:0]  bidir_port,
  output logic              irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_IRQMASK = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5
  } reg_addr_e;

  logic                               wr;
  logic [WIDTH-1:0]                   wdata;
  logic [WIDTH-1:0]                   data_out;
  logic [WIDTH-1:0]                   dir;
  logic [WIDTH-1:0]                   irq_mask;
  logic [WIDTH-1:0]                   edge_cap;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]                   sync_in;
  logic [WIDTH-1:0]                   prev;
  logic [WIDTH-1:0]                   edge_evt;
  logic [WIDTH-1:0]                   cap_clr;
  logic [31:0]                        rd_word;

  // Upper writedata bits above WIDTH are deliberately ignored.
  wire unused_wdata = &{1'b0, writedata};

  assign wr      = chipselect & ~write_n;
  assign wdata   = writedata[WIDTH-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Pin drive: per-bit tristate controlled by the direction register.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // -------------------------------------------------------------------------
  // Input synchroniser plus one extra sample for edge detection.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its neighbours, which is what makes this a
  // shift chain rather than a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bidir_port};
      prev   <= sync_in;
    end
  end

  // Event selection; the edge type is fixed at elaboration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    edge_evt = '0;
    case (EDGE_TYPE)
      0:       edge_evt = sync_in & ~prev;
      1:       edge_evt = ~sync_in & prev;
      default: edge_evt = sync_in ^ prev;
    endcase
  end

  assign cap_clr = (wr && address == REG_EDGECAP) ? wdata : '0;

  // Clear first, then OR in new events: a new event wins over a same-cycle
  // write-1-to-clear, so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
  end

  // -------------------------------------------------------------------------
  // Writable registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      irq_mask <= '0;
    end else if (wr) begin
      case (address)
        REG_DATA:    data_out <= wdata;
        REG_DIR:     dir      <= wdata;
        REG_IRQMASK: irq_mask <= wdata;
        REG_OUTSET:  data_out <= data_out | wdata;
        REG_OUTCLR:  data_out <= data_out & ~wdata;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read path: registered every cycle from the current address, regardless
  // of chipselect. Write-only and reserved addresses read zero.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    case (address)
      REG_DATA:    rd_word[WIDTH-1:0] = sync_in;
      REG_DIR:     rd_word[WIDTH-1:0] = dir;
      REG_IRQMASK: rd_word[WIDTH-1:0] = irq_mask;
      REG_EDGECAP: rd_word[WIDTH-1:0] = edge_cap;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_word;
  end

  // Built only from flop outputs, so it cannot glitch on bus activity.
  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_bidir_irq.sv
// ---------------------------------------------------------------------------
// tb_pio_bidir_irq
//   Self-checking bench. Instance u_dut (rising-edge capture, reset value
//   8'hA5) is tracked every cycle by a reference model built on a history of
//   sampled pin values. Instance u_dut_any (any-edge capture) shares the bus
//   and is checked with directed constants in the any-edge section.
// ---------------------------------------------------------------------------
module tb_pio_bidir_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  bus_addr;
  logic        bus_cs;
  logic        bus_wn;
  logic [31:0] bus_wdata;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  wire  [7:0]  pins_a, pins_b;

  // External pin drivers: the bench drives every pin the DUT is not driving.
  logic [7:0]  drv_a, drv_b;

  // Reference model state (shared bus, so dir is the same for both DUTs).
  logic [7:0]  dout_m, dir_m, mask_m, ecap_m;
  logic [7:0]  pin_hist[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pins_a[i] = dir_m[i] ? 1'bz : drv_a[i];
    assign pins_b[i] = dir_m[i] ? 1'bz : drv_b[i];
  end

  pio_bidir_irq #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(bus_addr), .chipselect(bus_cs),
    .write_n(bus_wn), .writedata(bus_wdata), .readdata(rd_a),
    .bidir_port(pins_a), .irq(irq_a)
  );

  pio_bidir_irq #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(bus_addr), .chipselect(bus_cs),
    .write_n(bus_wn), .writedata(bus_wdata), .readdata(rd_b),
    .bidir_port(pins_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dout_m = 8'hA5;
    dir_m  = 8'h00;
    mask_m = 8'h00;
    ecap_m = 8'h00;
    pin_hist.delete();
    repeat (3) pin_hist.push_back(8'h00);
  endtask

  task automatic bus_idle();
    bus_cs    = 1'b0;
    bus_wn    = 1'b1;
    bus_wdata = 32'h0;
  endtask

  // One clock cycle: sample pins, predict the post-edge state from the
  // register-map rules, let the edge happen, then compare at the negedge.
  task automatic tick();
    logic [7:0] p, s_now, s_prev, rd_x, ev, wd8, clr;
    logic [7:0] n_dout, n_dir, n_mask, n_ecap;
    logic       wr;
    int         n;
    #1;
    p = pins_a;
    check("pins_a", {24'h0, p}, {24'h0, (dir_m & dout_m) | (~dir_m & drv_a)});
    pin_hist.push_back(p);
    if (pin_hist.size() > 4) void'(pin_hist.pop_front());
    n      = pin_hist.size();
    s_now  = pin_hist[n-3];   // synchronised value seen by this edge
    s_prev = pin_hist[n-4];   // the one before it
    ev     = s_now & ~s_prev;
    wr     = bus_cs & ~bus_wn;
    wd8    = bus_wdata[7:0];
    case (bus_addr)
      3'd0:    rd_x = s_now;
      3'd1:    rd_x = dir_m;
      3'd2:    rd_x = mask_m;
      3'd3:    rd_x = ecap_m;
      default: rd_x = 8'h00;
    endcase
    n_dout = dout_m;
    n_dir  = dir_m;
    n_mask = mask_m;
    clr    = (wr && bus_addr == 3'd3) ? wd8 : 8'h00;
    n_ecap = (ecap_m & ~clr) | ev;
    if (wr) begin
      case (bus_addr)
        3'd0: n_dout = wd8;
        3'd1: n_dir  = wd8;
        3'd2: n_mask = wd8;
        3'd4: n_dout = dout_m | wd8;
        3'd5: n_dout = dout_m & ~wd8;
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    dout_m = n_dout;
    dir_m  = n_dir;
    mask_m = n_mask;
    ecap_m = n_ecap;
    check("readdata", rd_a, {24'h0, rd_x});
    check("irq", {31'h0, irq_a}, {31'h0, |(n_ecap & n_mask)});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_cs    = 1'b1;
    bus_wn    = 1'b0;
    bus_wdata = {24'hDEAD_00, d};
    tick();
    bus_idle();
  endtask

  initial begin
    reset_n  = 1'b0;
    bus_addr = 3'd0;
    bus_idle();
    drv_a = 8'h00;
    drv_b = 8'h00;
    model_reset();

    // Reset state, before any clock edge.
    #3;
    check("rst_readdata", rd_a, 32'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);
    check("rst_pins_z", {24'h0, pins_a}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Drive all pins: reset value appears on pins, then reads back as DATA.
    wr_reg(3'd1, 8'hFF);
    #1 check("pins_reset_value", {24'h0, pins_a}, 32'hA5);
    bus_addr = 3'd0;
    repeat (3) tick();
    check("data_reset_value", rd_a, 32'hA5);
    check("irq_idle", {31'h0, irq_a}, 32'h0);

    // Atomic set / clear.
    wr_reg(3'd0, 8'hF0);
    wr_reg(3'd4, 8'h0F);
    #1 check("pins_outset", {24'h0, pins_a}, 32'hFF);
    wr_reg(3'd5, 8'h81);
    #1 check("pins_outclr", {24'h0, pins_a}, 32'h7E);

    // Mixed direction with loopback on the low nibble.
    drv_a = 8'h50;
    wr_reg(3'd1, 8'h0F);
    bus_addr = 3'd0;
    repeat (3) tick();
    check("data_mixed_dir", rd_a, 32'h5E);

    // Rising-edge capture and interrupt on pin 2.
    drv_a = 8'h00;
    wr_reg(3'd1, 8'h00);
    wr_reg(3'd2, 8'h04);
    repeat (3) tick();
    wr_reg(3'd3, 8'hFF);
    repeat (3) tick();
    check("irq_cleared", {31'h0, irq_a}, 32'h0);
    drv_a = 8'h04;
    repeat (4) tick();
    check("irq_pin2", {31'h0, irq_a}, 32'h1);
    bus_addr = 3'd3;
    tick();
    check("edgecap_pin2", rd_a, 32'h04);
    wr_reg(3'd3, 8'h04);
    check("irq_after_clear", {31'h0, irq_a}, 32'h0);

    // Masked bit captures without raising irq.
    drv_a = 8'h0C;
    repeat (4) tick();
    bus_addr = 3'd3;
    tick();
    check("edgecap_pin3", rd_a, 32'h08);
    check("irq_masked", {31'h0, irq_a}, 32'h0);

    // New edge on the same edge as its write-1-clear: set wins.
    drv_a = 8'h08;
    repeat (3) tick();
    drv_a = 8'h0C;
    repeat (2) tick();
    wr_reg(3'd3, 8'h04);
    check("irq_set_wins", {31'h0, irq_a}, 32'h1);
    bus_addr = 3'd3;
    tick();
    check("edgecap_set_wins", rd_a, 32'h0C);

    // Any-edge instance: pulse pin 0 high for four cycles.
    wr_reg(3'd3, 8'hFF);
    drv_b = 8'h01;
    repeat (3) tick();
    bus_addr = 3'd3;
    tick();
    check("any_rise", rd_b, 32'h01);
    drv_b = 8'h00;
    wr_reg(3'd3, 8'h01);
    bus_addr = 3'd3;
    tick();
    check("any_cleared", rd_b, 32'h00);
    repeat (2) tick();
    check("any_fall", rd_b, 32'h01);

    // Single-cycle glitch: either outcome is legal, so it is only exercised.
    drv_b = 8'h01;
    tick();
    drv_b = 8'h00;
    repeat (4) tick();
    wr_reg(3'd3, 8'hFF);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus_addr  = 3'($urandom_range(0, 7));
      bus_cs    = 1'($urandom_range(0, 1));
      bus_wn    = 1'($urandom_range(0, 1));
      bus_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) drv_a = 8'($urandom);
      tick();
    end
    bus_idle();

    // Asynchronous reset with all edges captured and irq asserted.
    wr_reg(3'd1, 8'h00);
    wr_reg(3'd2, 8'hFF);
    drv_a = 8'h00;
    repeat (4) tick();
    wr_reg(3'd3, 8'hFF);
    drv_a = 8'hFF;
    repeat (4) tick();
    wr_reg(3'd1, 8'hFF);
    bus_addr = 3'd3;
    tick();
    check("pre_reset_edgecap", rd_a, 32'hFF);
    check("pre_reset_irq", {31'h0, irq_a}, 32'h1);
    bus_cs    = 1'b1;
    bus_wn    = 1'b0;
    bus_wdata = 32'h0000_0000;
    #2;
    reset_n = 1'b0;
    dir_m   = 8'h00;
    drv_a   = 8'h00;
    #1;
    check("async_rst_irq", {31'h0, irq_a}, 32'h0);
    check("async_rst_readdata", rd_a, 32'h0);
    check("async_rst_pins_z", {24'h0, pins_a}, 32'h0);
    model_reset();
    bus_idle();
    bus_addr = 3'd1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_dir", rd_a, 32'h0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
